remote_comm: RTL and testbench
==============================

Name: remote_comm

Overview:
- Host-side command transmitter used by the robot test environment. It models the Bluetooth/remote controller.
- Accepts a 16-bit command and serialises it over UART as two bytes, high byte first.
- Receives single-byte responses (for example 0xA5 acknowledgements) on its RX line and presents them with a ready flag.
- Pairs with the robot-side UART wrapper: TX drives the robot RX, RX is driven by the robot TX.

Parameters:
- BAUD_DIV, default 2604: clocks per UART bit (50 MHz clock / 19200 baud).

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- cmd, input, 16: command word to send; sampled on the snd_cmd cycle.
- snd_cmd, input, 1: single-cycle pulse requesting transmission of cmd.
- TX, output, 1: UART serial out, idle high.
- RX, input, 1: UART serial in, idle high, asynchronous to clk.
- resp, output, 8: last received response byte.
- resp_rdy, output, 1: response byte valid.
- cmd_snt, output, 1: both command bytes fully transmitted.

Behaviour:
- Line format: 8N1. Start bit 0, eight data bits LSB first, one stop bit 1. Each bit lasts BAUD_DIV clocks.
- Reset values: TX=1, cmd_snt=0, resp_rdy=0, resp=0x00. All state machines return to IDLE.
- Reset asserted mid-operation aborts any frame immediately. TX returns high in the same cycle the reset is asserted.
- Command capture:
  - On a clk edge with snd_cmd=1 in IDLE, latch cmd[7:0] into a low-byte holding register.
  - Load cmd[15:8] into the transmitter and clear cmd_snt.
- Command FSM states:
  - IDLE -> HIGH (on snd_cmd).
  - HIGH -> LOW when the high byte's stop bit completes; start the low byte on the next cycle.
  - LOW -> IDLE when the low byte's stop bit completes; set cmd_snt=1 that cycle.
- Total latency from snd_cmd to cmd_snt rising: 20*BAUD_DIV + at most 3 clocks.
- cmd_snt stays high until the next accepted snd_cmd, so every command produces one rising edge.
- snd_cmd while not IDLE is ignored. The in-flight command is unaffected.
- Transmitter:
  - 10-bit shift register {stop, data, start}, shifting LSB out.
  - Baud counter counts to BAUD_DIV-1. Bit counter counts 0..10. The done pulse is one cycle wide.
- Receiver:
  - RX passes through a two-flop synchroniser, metastability-safe, preset to 1 on reset.
  - A falling edge in idle starts a frame.
  - The first sample is taken at BAUD_DIV/2, then every BAUD_DIV. Nine bits are shifted in: start plus eight data.
  - After the 8th data bit is sampled, resp is loaded with the data byte and resp_rdy=1.
  - Stop bit is not checked. Framing errors are not reported.
- resp_rdy stays high until either a new start bit is detected or snd_cmd is accepted. Each received byte therefore yields a distinct rising edge.
- Simultaneous events:
  - Receiving and transmitting are fully independent and may overlap.
  - A new start bit in the same cycle as the 8th sample cannot occur, since the stop bit is still in progress.
  - If snd_cmd and byte completion coincide, resp_rdy is set: completion wins.

Decomposition:
- Shared package constants: BAUD_DIV default; UART frame length of 10 bits.
- One natural sub-module: uart_xcvr, containing UART_tx plus UART_rx with trmt/tx_data/tx_done and rdy/rx_data/clr_rdy.
- remote_comm adds the two-byte sequencer, low-byte holding register and cmd_snt flop on top of uart_xcvr.

Test Plan:
- Reset then idle 100 clocks -> TX=1, cmd_snt=0, resp_rdy=0, resp=0x00.
- snd_cmd with cmd=0x2000; decode TX with a bench UART receiver -> bytes 0x20 then 0x00, LSB first. cmd_snt rises at 20*2604 ±3 clocks and stays high.
- Loop TX through a UART_wrapper-style receiver; send cmd=0x4001 -> assembled 16-bit word equals 0x4001. cmd_snt falls on snd_cmd and rises again at end of frame.
- Drive RX with a frame of byte 0xA5 -> resp=0xA5 and resp_rdy rises mid-8th data bit. A second 0xA5 frame -> resp_rdy drops at its start bit and rises again.
- Pulse snd_cmd (cmd=0x1234) during an active transmission -> ignored. Only the first command's two bytes appear on TX.
- Assert rst_n=0 mid-byte -> TX=1 immediately, cmd_snt=0. A new snd_cmd after release sends the full frame correctly.

Source files
------------

// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared UART constants and the command sequencer state type
package remote_comm_pkg;
  localparam int BAUD_DIV_DEF = 2604;
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} cmd_state_e;
endpackage

// File: rtl/remote_comm_uart_xcvr.sv
// uart_xcvr: independent 8N1 UART transmitter and receiver sharing one baud divisor
module uart_xcvr
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_done_o,
  output logic       tx_o,
  input  logic       rx_i,
  input  logic       clr_rdy_i,
  output logic       rdy_o,
  output logic [7:0] rx_data_o
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
  logic [FRAME_BITS-1:0] tx_sh_q;
  logic                  tx_busy_q, tx_done_q;
  logic [BW-1:0]         tx_baud_q, rx_baud_q;
  logic [3:0]            tx_bit_q, rx_bit_q;
  logic                  rx_s1_q, rx_s2_q, rx_prev_q, rx_busy_q, rdy_q;
  logic [6:0]            rx_sh_q;
  logic [7:0]            rx_data_q;
  logic                  tx_tick, rx_start, rx_sample, rx_last;
  assign tx_tick   = tx_busy_q && tx_baud_q == LAST;
  assign rx_start  = !rx_busy_q && rx_prev_q && !rx_s2_q;
  assign rx_sample = rx_busy_q && rx_baud_q == (rx_bit_q == 4'd0 ? HALF : LAST);
  assign rx_last   = rx_sample && rx_bit_q == 4'd8;
  assign tx_o      = tx_sh_q[0];
  assign tx_done_o = tx_done_q;
  assign rdy_o     = rdy_q;
  assign rx_data_o = rx_data_q;
  // Transmit: load {stop, data, start} and shift one bit out per baud period; ones fill behind so the line idles high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_sh_q   <= '1;
      tx_busy_q <= 1'b0;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_tick && tx_bit_q == 4'(FRAME_BITS - 1);
      if (trmt_i && !tx_busy_q) begin
        tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
        tx_busy_q <= 1'b1;
        tx_baud_q <= '0;
        tx_bit_q  <= '0;
      end else if (tx_tick) begin
        tx_sh_q   <= {1'b1, tx_sh_q[FRAME_BITS-1:1]};
        tx_baud_q <= '0;
        tx_bit_q  <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'(FRAME_BITS - 1)) tx_busy_q <= 1'b0;
      end else if (tx_busy_q) tx_baud_q <= tx_baud_q + 1'b1;
    end
  // Two-flop synchroniser plus one delayed copy for falling-edge detection, all idle high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s1_q, rx_s2_q, rx_prev_q} <= 3'b111;
    else {rx_s1_q, rx_s2_q, rx_prev_q} <= {rx_i, rx_s1_q, rx_s2_q};
  // Receive: sample mid-bit, keep the last seven samples; the ninth sample completes the data byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_busy_q <= 1'b0;
      rx_baud_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else if (rx_start) begin
      rx_busy_q <= 1'b1;
      rx_baud_q <= '0;
      rx_bit_q  <= '0;
    end else if (rx_sample) begin
      rx_sh_q   <= {rx_s2_q, rx_sh_q[6:1]};
      rx_baud_q <= '0;
      rx_bit_q  <= rx_bit_q + 4'd1;
      if (rx_last) begin
        rx_busy_q <= 1'b0;
        rx_data_q <= {rx_s2_q, rx_sh_q};
      end
    end else if (rx_busy_q) rx_baud_q <= rx_baud_q + 1'b1;
  // Ready flag: byte completion wins over clearing by a new start bit or an external clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_q <= 1'b0;
    else rdy_q <= rx_last ? 1'b1 : (rx_start || clr_rdy_i) ? 1'b0 : rdy_q;
endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes (high first) and reports received response bytes
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        cmd_snt
);
  cmd_state_e state_q, state_d;
  logic [7:0] low_q, tx_data;
  logic       cmd_snt_q, accept, trmt, tx_done;
  uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk       (clk),
    .rst_n     (rst_n),
    .trmt_i    (trmt),
    .tx_data_i (tx_data),
    .tx_done_o (tx_done),
    .tx_o      (TX),
    .rx_i      (RX),
    .clr_rdy_i (accept),
    .rdy_o     (resp_rdy),
    .rx_data_o (resp)
  );
  assign cmd_snt = cmd_snt_q;
  // Sequencer: accept only in IDLE, chain the low byte straight after the high byte's done pulse
  always_comb begin
    accept  = snd_cmd && state_q == IDLE;
    trmt    = accept || (state_q == HIGH && tx_done);
    tx_data = state_q == IDLE ? cmd[15:8] : low_q;
    state_d = accept ? HIGH : !tx_done ? state_q : state_q == HIGH ? LOW : state_q == LOW ? IDLE : state_q;
  end
  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Low-byte holding register and sent flag that stays high until the next accepted command
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      low_q     <= '0;
      cmd_snt_q <= 1'b0;
    end else begin
      low_q     <= accept ? cmd[7:0] : low_q;
      cmd_snt_q <= accept ? 1'b0 : (state_q == LOW && tx_done) ? 1'b1 : cmd_snt_q;
    end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed self-checking bench for the remote_comm command transmitter and response receiver
module tb_remote_comm;
  localparam int B = 16;
  logic        clk = 1'b0, rst_n = 1'b0, snd_cmd = 1'b0, RX = 1'b1;
  logic [15:0] cmd = '0;
  logic        TX, resp_rdy, cmd_snt;
  logic [7:0]  resp;
  int          tests = 0, fails = 0, cyc = 0, c0 = 0;
  logic [8:0]  txq[$];

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .TX       (TX),
    .RX       (RX),
    .resp     (resp),
    .resp_rdy (resp_rdy),
    .cmd_snt  (cmd_snt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && !TX) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        txq.push_back({TX, b});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    c0 = cyc;
    chk("cmd_snt_cleared", {31'd0, cmd_snt}, 32'd0);
  endtask

  task automatic finish_cmd(input logic [15:0] c);
    int n;
    int lat;
    logic [8:0] hi, lo;
    n = 0;
    while (txq.size() < 2 && n < 25 * B) begin
      @(negedge clk);
      n++;
    end
    chk("tx_byte_count", txq.size(), 32'd2);
    hi = txq.size() > 0 ? txq.pop_front() : 9'h0;
    lo = txq.size() > 0 ? txq.pop_front() : 9'h0;
    chk("tx_word", {16'd0, hi[7:0], lo[7:0]}, {16'd0, c});
    chk("tx_stop_bits", {30'd0, hi[8], lo[8]}, 32'd3);
    n = 0;
    while (!cmd_snt && n < 4 * B) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - c0;
    tests++;
    assert (cmd_snt && lat >= 20 * B && lat <= 20 * B + 3) else begin
      fails++;
      $error("FAIL cmd_snt_latency: observed %0d clocks (cmd_snt=%0b) expected %0d..%0d", lat, cmd_snt, 20 * B, 20 * B + 3);
    end
  endtask

  task automatic drive_rx(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (B / 2) @(negedge clk);
    chk("resp_rdy_start_clr", {31'd0, resp_rdy}, 32'd0);
    repeat (B - B / 2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = b[7];
    repeat (B / 4) @(negedge clk);
    chk("resp_rdy_early", {31'd0, resp_rdy}, 32'd0);
    repeat (B - B / 4 - 1) @(negedge clk);
    chk("resp_rdy_set", {31'd0, resp_rdy}, 32'd1);
    chk("resp_value", {24'd0, resp}, {24'd0, b});
    @(negedge clk);
    RX = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("reset_tx", {31'd0, TX}, 32'd1);
    chk("reset_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    chk("reset_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("reset_resp", {24'd0, resp}, 32'd0);

    start_cmd(16'h2000);
    finish_cmd(16'h2000);
    repeat (50) @(negedge clk);
    chk("cmd_snt_holds", {31'd0, cmd_snt}, 32'd1);

    start_cmd(16'h4001);
    finish_cmd(16'h4001);

    drive_rx(8'hA5);
    repeat (20) @(negedge clk);
    chk("resp_rdy_holds", {31'd0, resp_rdy}, 32'd1);
    drive_rx(8'hA5);
    drive_rx(8'h3C);

    start_cmd(16'h5A3C);
    chk("resp_rdy_cleared_by_cmd", {31'd0, resp_rdy}, 32'd0);
    chk("resp_kept", {24'd0, resp}, 32'h3C);
    repeat (3 * B) @(negedge clk);
    cmd = 16'h1234;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    finish_cmd(16'h5A3C);
    repeat (15 * B) @(negedge clk);
    chk("ignored_cmd_no_extra", txq.size(), 32'd0);

    start_cmd(16'hC3A1);
    repeat (3 * B + 5) @(negedge clk);
    chk("tx_low_before_reset", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_tx", {31'd0, TX}, 32'd1);
    chk("reset_mid_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    chk("reset_mid_resp", {24'd0, resp}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * B) @(negedge clk);
    txq.delete();
    start_cmd(16'hBEEF);
    finish_cmd(16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
